// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, stage indices and
// the per-stage register command encoding.
package pipe_pkg;

   localparam int          DEF_DATA_W     = 32;
   localparam logic [31:0] DEF_BUBBLE_VAL = '0;

   localparam int STG_IFID  = 0;
   localparam int STG_IDEX  = 1;
   localparam int STG_EXMEM = 2;
   localparam int STG_MEMWB = 3;

   typedef enum logic [1:0] {
      CMD_LOAD,
      CMD_HOLD,
      CMD_BUBBLE,
      CMD_KILL
   } stage_cmd_e;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline boundary register (payload + valid) driven by a
// decoded command from the chain controller.
module pipe_stage_cell
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = DEF_DATA_W,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  stage_cmd_e        cmd,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_valid,
   output logic [DATA_W-1:0] q_data,
   output logic              q_valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q_data  <= BUBBLE_VAL;
         q_valid <= 1'b0;
      end else begin
         unique case (cmd)
            CMD_LOAD: begin
               q_data  <= d_data;
               q_valid <= d_valid;
            end
            CMD_HOLD: begin
               q_data  <= q_data;
               q_valid <= q_valid;
            end
            CMD_BUBBLE,
            CMD_KILL: begin
               q_data  <= BUBBLE_VAL;
               q_valid <= 1'b0;
            end
            default: begin
               q_data  <= BUBBLE_VAL;
               q_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic pipeline register chain with hold/kill per stage, automatic
// bubble insertion below held stages and saturating perf counters.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int                NUM_STAGES = 4,
   parameter int                DATA_W     = DEF_DATA_W,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                COUNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_STAGES-1:0]        stall,
   input  logic [NUM_STAGES-1:0]        flush,
   input  logic                         cnt_clr,
   output logic [NUM_STAGES*DATA_W-1:0] stage_data,
   output logic [NUM_STAGES-1:0]        stage_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   output logic [COUNT_W-1:0]           stall_cnt,
   output logic [COUNT_W-1:0]           bubble_cnt
);

   logic [NUM_STAGES-1:0] h;
   stage_cmd_e            cmd [NUM_STAGES];
   logic [DATA_W-1:0]     q_data [NUM_STAGES];
   logic                  bubble_ev;

   // Hold propagates from the oldest stage toward the youngest.
   always_comb begin
      h = '0;
      h[NUM_STAGES-1] = stall[NUM_STAGES-1];
      for (int i = NUM_STAGES-2; i >= 0; i--)
         h[i] = stall[i] | h[i+1];
   end

   always_comb begin
      bubble_ev = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         cmd[i] = CMD_LOAD;
         if (flush[i])
            cmd[i] = CMD_KILL;
         else if (h[i])
            cmd[i] = CMD_HOLD;
         else if (i > 0 && h[(i > 0) ? i-1 : 0]) begin
            cmd[i]    = CMD_BUBBLE;
            bubble_ev = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
      logic [DATA_W-1:0] d_data;
      logic              d_valid;

      if (g == 0) begin : g_head
         assign d_data  = in_data;
         assign d_valid = in_valid;
      end else begin : g_body
         assign d_data  = q_data[g-1];
         assign d_valid = stage_valid[g-1];
      end

      pipe_stage_cell #(
         .DATA_W     (DATA_W),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) u_cell (
         .clk     (clk),
         .reset   (reset),
         .cmd     (cmd[g]),
         .d_data  (d_data),
         .d_valid (d_valid),
         .q_data  (q_data[g]),
         .q_valid (stage_valid[g])
      );

      assign stage_data[g*DATA_W +: DATA_W] = q_data[g];
   end

   assign in_ready  = ~h[0];
   assign out_data  = q_data[NUM_STAGES-1];
   assign out_valid = stage_valid[NUM_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (h[0] && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (bubble_ev && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed table-driven bench for pipe_stage_chain (4 stages, 8-bit
// payload, 4-bit counters) plus a counter saturation sequence.
module tb_pipe_stage_chain;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  stall;
   logic [3:0]  flush;
   logic        cnt_clr;
   logic [31:0] stage_data;
   logic [3:0]  stage_valid;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [3:0]  stall_cnt;
   logic [3:0]  bubble_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_chain #(
      .NUM_STAGES (4),
      .DATA_W     (8),
      .BUBBLE_VAL (8'h00),
      .COUNT_W    (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .stall       (stall),
      .flush       (flush),
      .cnt_clr     (cnt_clr),
      .stage_data  (stage_data),
      .stage_valid (stage_valid),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .stall_cnt   (stall_cnt),
      .bubble_cnt  (bubble_cnt)
   );

   typedef struct {
      logic        rst;
      logic [7:0]  din;
      logic        vin;
      logic [3:0]  st;
      logic [3:0]  fl;
      logic        clr;
      logic [31:0] e_data;
      logic [3:0]  e_valid;
      logic        e_rdy;
      logic [3:0]  e_sc;
      logic [3:0]  e_bc;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic [7:0] d, input logic v,
                      input logic [3:0] s, input logic [3:0] f,
                      input logic c, input logic [31:0] ed,
                      input logic [3:0] ev, input logic er,
                      input logic [3:0] esc, input logic [3:0] ebc);
      vec_t x;
      x.rst = r; x.din = d; x.vin = v; x.st = s; x.fl = f; x.clr = c;
      x.e_data = ed; x.e_valid = ev; x.e_rdy = er;
      x.e_sc = esc; x.e_bc = ebc;
      tbl.push_back(x);
   endtask

   task automatic drive(input logic r, input logic [7:0] d,
                        input logic v, input logic [3:0] s,
                        input logic [3:0] f, input logic c);
      reset = r; in_data = d; in_valid = v;
      stall = s; flush = f; cnt_clr = c;
   endtask

   initial begin
      drive(1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);
      // stage order in expected data: {s3,s2,s1,s0}
      add(1,8'h00,0,4'b0000,4'b0000,0,32'h00_00_00_00,4'b0000,1,0,0);
      add(0,8'h10,1,4'b0000,4'b0000,0,32'h00_00_00_10,4'b0001,1,0,0);
      add(0,8'h11,1,4'b0000,4'b0000,0,32'h00_00_10_11,4'b0011,1,0,0);
      add(0,8'h12,1,4'b0000,4'b0000,0,32'h00_10_11_12,4'b0111,1,0,0);
      add(0,8'h13,1,4'b0000,4'b0000,0,32'h10_11_12_13,4'b1111,1,0,0);
      add(0,8'h14,1,4'b0010,4'b0000,0,32'h11_00_12_13,4'b1011,0,1,1);
      add(0,8'h14,1,4'b0000,4'b0000,0,32'h00_12_13_14,4'b0111,1,1,1);
      add(0,8'h15,1,4'b0000,4'b0000,0,32'h12_13_14_15,4'b1111,1,1,1);
      add(0,8'h16,1,4'b0010,4'b0010,0,32'h13_00_00_15,4'b1001,0,2,2);
      add(0,8'h17,1,4'b0000,4'b0000,0,32'h00_00_15_17,4'b0011,1,2,2);
      add(0,8'hAA,1,4'b0000,4'b0011,0,32'h00_15_00_00,4'b0100,1,2,2);
      add(0,8'h00,0,4'b0000,4'b0000,0,32'h15_00_00_00,4'b1000,1,2,2);
      add(0,8'h21,1,4'b0000,4'b0000,0,32'h00_00_00_21,4'b0001,1,2,2);
      add(0,8'h22,1,4'b0000,4'b0000,0,32'h00_00_21_22,4'b0011,1,2,2);
      add(0,8'h23,1,4'b0000,4'b0000,0,32'h00_21_22_23,4'b0111,1,2,2);
      add(0,8'h24,1,4'b0000,4'b0000,0,32'h21_22_23_24,4'b1111,1,2,2);
      add(0,8'h25,1,4'b1000,4'b1000,0,32'h00_22_23_24,4'b0111,0,3,2);
      add(0,8'h25,1,4'b1111,4'b0000,0,32'h00_22_23_24,4'b0111,0,4,2);
      add(1,8'h25,1,4'b1111,4'b0000,0,32'h00_00_00_00,4'b0000,0,0,0);
      add(0,8'h25,1,4'b1111,4'b0000,0,32'h00_00_00_00,4'b0000,0,1,0);

      foreach (tbl[k]) begin
         drive(tbl[k].rst, tbl[k].din, tbl[k].vin,
               tbl[k].st, tbl[k].fl, tbl[k].clr);
         @(posedge clk);
         #1;
         check($sformatf("v%0d data", k), stage_data, tbl[k].e_data);
         check($sformatf("v%0d valid", k), {28'd0, stage_valid},
               {28'd0, tbl[k].e_valid});
         check($sformatf("v%0d out_data", k), {24'd0, out_data},
               {24'd0, tbl[k].e_data[31:24]});
         check($sformatf("v%0d out_valid", k), {31'd0, out_valid},
               {31'd0, tbl[k].e_valid[3]});
         check($sformatf("v%0d in_ready", k), {31'd0, in_ready},
               {31'd0, tbl[k].e_rdy});
         check($sformatf("v%0d stall_cnt", k), {28'd0, stall_cnt},
               {28'd0, tbl[k].e_sc});
         check($sformatf("v%0d bubble_cnt", k), {28'd0, bubble_cnt},
               {28'd0, tbl[k].e_bc});
      end

      // saturation: stall[0] alone holds stage 0 and bubbles stage 1
      drive(1'b1, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 8'h33, 1'b1, 4'b0001, 4'h0, 1'b0);
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 14 || n == 15 || n == 16 || n == 20) begin
            check($sformatf("sat%0d stall_cnt", n), {28'd0, stall_cnt},
                  (n < 15) ? n : 15);
            check($sformatf("sat%0d bubble_cnt", n), {28'd0, bubble_cnt},
                  (n < 15) ? n : 15);
         end
      end
      check("sat in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 8'h33, 1'b1, 4'b0001, 4'h0, 1'b1);
      @(posedge clk);
      #1;
      check("clr stall_cnt", {28'd0, stall_cnt}, 32'd0);
      check("clr bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
      drive(1'b0, 8'h33, 1'b1, 4'b0001, 4'h0, 1'b0);
      @(posedge clk);
      #1;
      check("post clr stall_cnt", {28'd0, stall_cnt}, 32'd1);
      check("post clr bubble_cnt", {28'd0, bubble_cnt}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised pipeline-register chain that replaces the hand-written per-boundary stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with one generic block.
- Each stage carries a DATA_W payload (control bundle and/or operands) plus a valid bit.
- Each stage has independent hold (stall) and kill (flush) controls from the hazard unit.
- Bubbles are inserted automatically below a held stage; saturating stall and bubble performance counters are included.
- Stage 0 is youngest (IF/ID position); stage NUM_STAGES-1 is oldest (MEM/WB position).

Parameters:
- NUM_STAGES, 4: number of register stages (≥2).
- DATA_W, 32: payload width per stage.
- BUBBLE_VAL, 0: payload value loaded on reset, flush or bubble insertion.
- COUNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- in_data  in  DATA_W  payload entering stage 0.
- in_valid  in  1  payload qualifier for stage 0.
- in_ready  out  1  stage 0 accepts in_data this cycle (= ~h[0]).
- stall  in  NUM_STAGES  per-stage hold request.
- flush  in  NUM_STAGES  per-stage kill request.
- cnt_clr  in  1  synchronous clear of both counters.
- stage_data  out  NUM_STAGES*DATA_W  all stage payloads; stage i at [i*DATA_W +: DATA_W].
- stage_valid  out  NUM_STAGES  per-stage valid.
- out_data  out  DATA_W  stage NUM_STAGES-1 payload.
- out_valid  out  1  stage NUM_STAGES-1 valid.
- stall_cnt  out  COUNT_W  cycles in which h[0]=1.
- bubble_cnt  out  COUNT_W  cycles in which at least one bubble was inserted.

Behaviour:
- Effective hold (combinational, computed from oldest stage downward):
  - h[N-1] = stall[N-1].
  - h[i] = stall[i] | h[i+1].
  - A stall at stage k therefore freezes stages 0..k.
- Per-stage update priority, stage i, each rising edge:
  1. reset: valid=0, data=BUBBLE_VAL.
  2. flush[i]: valid=0, data=BUBBLE_VAL. Flush beats hold.
  3. h[i]: retain data and valid.
  4. i>0 and h[i-1]: bubble (valid=0, data=BUBBLE_VAL).
  5. Otherwise advance: stage 0 loads in_data/in_valid; stage i>0 loads stage i-1.
- Reset is unconditional. It does not depend on hold/enable, unlike the legacy IF/ID register, which ignored reset while load was low.
- Latency:
  - A word captured into stage 0 at edge t appears at out_data/out_valid after edge t+NUM_STAGES-1, provided there are no holds.
  - Each held cycle adds 1 cycle of latency.
- Handshake:
  - in_ready is combinational from stall.
  - Upstream must hold in_data while in_ready=0. The block ignores in_data on those cycles.
  - in_valid=0 with in_ready=1 loads a bubble into stage 0.
- Flush of a held stage:
  - The flushed stage becomes a bubble.
  - Stages below it continue to hold if their h is set.
  - The stage directly above the flushed stage is unaffected by the flush.
- Valid does not gate hold: a held stage with valid=0 still holds.
- Counters:
  - Priority: reset/cnt_clr → 0; else increment if event, saturating at all-ones.
  - stall_cnt event: h[0]=1.
  - bubble_cnt event: any i>0 satisfies rule 4 (not suppressed by flush[i]).
  - cnt_clr and an event in the same cycle → 0.
- Reset values:
  - All stage_valid=0, all stage_data=BUBBLE_VAL, out_valid=0.
  - stall_cnt=0, bubble_cnt=0.
  - in_ready reflects stall combinationally (1 when stall=0).

Decomposition:
- Shared package pipe_pkg:
  - Default DATA_W/BUBBLE_VAL.
  - Named stage indices (STG_IFID=0, STG_IDEX=1, STG_EXMEM=2, STG_MEMWB=3).
  - Typedef for the stage command encoding {LOAD, HOLD, BUBBLE, KILL}.
- Sub-module pipe_stage_cell:
  - One DATA_W+1 register with the 4-way command input.
  - Instantiated NUM_STAGES times by a generate loop.
- Hold chain, per-stage command decode and counters stay in the top module.

Test Plan (NUM_STAGES=4, DATA_W=8, BUBBLE_VAL=0, COUNT_W=4):
- Stream: reset, then in_data=0x10..0x15 valid on consecutive cycles with stall=flush=0 → out_data=0x10 valid 3 edges after capture, then consecutive values; counters stay 0.
- Mid-stall: pipe full (0x13,0x12,0x11,0x10 in stages 0..3), stall=4'b0010 for 1 cycle → stages 0,1 keep 0x13,0x12; stage 2 valid=0 data=0; stage 3=0x11; in_ready=0; stall_cnt=1, bubble_cnt=1.
- Flush beats hold: stall=4'b0010 and flush=4'b0010 in the same cycle → stage 1 valid=0 data=0; stage 0 held; stage 2 bubble; bubble_cnt +1.
- Multi-flush (branch): flush=4'b0011 with in_valid=1 in_data=0xAA → stages 0,1 become bubbles (0xAA discarded); stage 2 advances from old stage 1.
- Reset mid-operation: stall=4'b1111 with full pipe, reset for 1 cycle → all valid=0, data=0, counters 0; in_ready stays 0 while stall is held.
- Saturation: stall[0]=1 for 20 cycles → stall_cnt stays 15; assert cnt_clr during a stall cycle → stall_cnt=0.
